pulse_reg_queue: RTL and testbench
==================================

Name: pulse_reg_queue

Overview:
- Parametrised successor to the single-entry pulse register.
- Per-field staging registers hold the current phase, freq, amp, env word and cfg; cstrobe_in commits the assembled pulse word into a DEPTH-entry FIFO.
- Downstream (element/sequencer side) pops with a ready handshake; each pop drives registered pulse outputs plus a one-cycle cstrobe.
- Decouples processor write timing from pulse issue timing and adds occupancy/overflow reporting.

Parameters:
PHASE_WIDTH, 17, phase offset width
FREQ_WIDTH, 9, frequency word width
AMP_WIDTH, 16, amplitude width
CFG_WIDTH, 4, mode + dest bits
ENV_WORD_WIDTH, 24, envelope addr MSBs + length LSBs
DEPTH, 8, FIFO entries; power of 2, >=2
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock, reset is asynchronous and active-low
phase_offs_in  in  PHASE_WIDTH  phase staging data
freq_in  in  FREQ_WIDTH  freq staging data
amp_in  in  AMP_WIDTH  amp staging data
env_word_in  in  ENV_WORD_WIDTH  env staging data
cfg_in  in  CFG_WIDTH  cfg staging data
phase_write_en, freq_write_en, amp_write_en, env_word_write_en, cfg_write_en  in  1 each  field write strobes
cstrobe_in  in  1  commit staged word to FIFO
out_ready  in  1  downstream accepts next pulse
overflow_clr  in  1  clears overflow flag
phase  out  PHASE_WIDTH  issued pulse phase
freq  out  FREQ_WIDTH  issued pulse freq
amp  out  AMP_WIDTH  issued pulse amp
env_word  out  ENV_WORD_WIDTH  issued pulse env word
cfg  out  CFG_WIDTH  issued pulse cfg
cstrobe  out  1  one-cycle pulse: outputs carry a newly issued pulse
out_valid  out  1  FIFO non-empty
level  out  CNT_WIDTH  FIFO occupancy
full  out  1  level == DEPTH
overflow  out  1  sticky: a commit was dropped

Behaviour:
- Reset (rstn low, async): staging regs, FIFO pointers, level, all outputs = 0; out_valid=0, full=0, overflow=0, cstrobe=0. FIFO storage need not be cleared. Reset mid-operation discards all queued entries.
- Staging: each field is updated independently at the clk edge when its write_en is high; otherwise it holds. Staged values persist across commits; unwritten fields repeat their last value.
- Commit word per field = write_en ? input : staged. A field written in the same cycle as cstrobe_in enters the committed entry with the new value.
- Push = cstrobe_in & (!full | pop). Pop = out_valid & out_ready.
- cstrobe_in while full with no pop: entry dropped, FIFO unchanged, overflow <= 1.
- Full with simultaneous pop: push accepted, level unchanged.
- Push and pop in the same cycle (non-empty): level unchanged, pointers both advance, mod DEPTH wrap.
- Empty: no pop regardless of out_ready; no same-cycle bypass. The first commit is visible as out_valid in the next cycle.
- On pop at edge N: phase/freq/amp/env_word/cfg <= head entry and cstrobe <= 1 for exactly one cycle. Otherwise cstrobe <= 0 and the outputs hold the last issued pulse.
- Latency: cstrobe_in in cycle N into an empty FIFO with out_ready=1 gives out_valid in N+1 and cstrobe/outputs valid in N+2. Back-to-back pops give cstrobe every cycle.
- level, full, out_valid are registered and consistent with pointers in the same cycle.
- overflow: set wins over overflow_clr when both occur in the same cycle.

Test Plan:
- Write phase=0x1ABCD, freq=0x55, amp=0x7FFF, env=0x123040, cfg=0x9; cstrobe_in next cycle, out_ready=1 -> out_valid cycle+1, cstrobe cycle+2 with exactly those values, level back to 0.
- Same-cycle amp_write_en amp=0x0100 + cstrobe_in after a prior commit with amp=0x7FFF -> second issued pulse amp=0x0100, other fields repeat previous values.
- out_ready=0, 9 commits with DEPTH=8 -> level=8, full=1, overflow=1. Release out_ready -> 8 cstrobes in consecutive cycles, FIFO order preserved, 9th entry absent. overflow_clr -> overflow=0.
- Full with out_ready=1 and cstrobe_in every cycle for 20 cycles -> no overflow, level stays 8, pointer wrap correct, output order matches commit order.
- Assert rstn low asynchronously mid-drain with 5 entries queued -> all outputs 0 immediately, level=0, no cstrobe after release until a new commit.
- out_ready toggling 1/0 with commits every 3rd cycle -> exactly one cstrobe per commit, never while empty, outputs held between strobes.

Source files
------------

// File: rtl/pulse_reg_queue.sv
// Pulse register queue: per-field staging registers feed a DEPTH-entry FIFO
// of assembled pulse words. The downstream side pops with a ready handshake;
// every pop registers the head entry onto the pulse outputs together with a
// single-cycle cstrobe. Occupancy, full and a sticky overflow flag are
// reported alongside.
module pulse_reg_queue #(
  parameter int PHASE_WIDTH    = 17,
  parameter int FREQ_WIDTH     = 9,
  parameter int AMP_WIDTH      = 16,
  parameter int CFG_WIDTH      = 4,
  parameter int ENV_WORD_WIDTH = 24,
  parameter int DEPTH          = 8,
  parameter int CNT_WIDTH      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PHASE_WIDTH-1:0]    phase_offs_in,
  input  logic [FREQ_WIDTH-1:0]     freq_in,
  input  logic [AMP_WIDTH-1:0]      amp_in,
  input  logic [ENV_WORD_WIDTH-1:0] env_word_in,
  input  logic [CFG_WIDTH-1:0]      cfg_in,
  input  logic                      phase_write_en,
  input  logic                      freq_write_en,
  input  logic                      amp_write_en,
  input  logic                      env_word_write_en,
  input  logic                      cfg_write_en,
  input  logic                      cstrobe_in,
  input  logic                      out_ready,
  input  logic                      overflow_clr,
  output logic [PHASE_WIDTH-1:0]    phase,
  output logic [FREQ_WIDTH-1:0]     freq,
  output logic [AMP_WIDTH-1:0]      amp,
  output logic [ENV_WORD_WIDTH-1:0] env_word,
  output logic [CFG_WIDTH-1:0]      cfg,
  output logic                      cstrobe,
  output logic                      out_valid,
  output logic [CNT_WIDTH-1:0]      level,
  output logic                      full,
  output logic                      overflow
);

  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_WIDTH = PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH
                             + ENV_WORD_WIDTH + CFG_WIDTH;

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] ONE_PTR   = PTR_WIDTH'(1);

  // Staging registers
  logic [PHASE_WIDTH-1:0]    phase_stg;
  logic [FREQ_WIDTH-1:0]     freq_stg;
  logic [AMP_WIDTH-1:0]      amp_stg;
  logic [ENV_WORD_WIDTH-1:0] env_word_stg;
  logic [CFG_WIDTH-1:0]      cfg_stg;

  // FIFO storage and bookkeeping
  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;

  logic [PHASE_WIDTH-1:0]    phase_cmt;
  logic [FREQ_WIDTH-1:0]     freq_cmt;
  logic [AMP_WIDTH-1:0]      amp_cmt;
  logic [ENV_WORD_WIDTH-1:0] env_word_cmt;
  logic [CFG_WIDTH-1:0]      cfg_cmt;
  logic [ENTRY_WIDTH-1:0]    commit_word;
  logic [ENTRY_WIDTH-1:0]    head_word;

  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [CNT_WIDTH-1:0] level_next;

  // Commit word: a field written in the commit cycle goes in with its new value
  always_comb begin
    phase_cmt    = phase_write_en    ? phase_offs_in : phase_stg;
    freq_cmt     = freq_write_en     ? freq_in       : freq_stg;
    amp_cmt      = amp_write_en      ? amp_in        : amp_stg;
    env_word_cmt = env_word_write_en ? env_word_in   : env_word_stg;
    cfg_cmt      = cfg_write_en      ? cfg_in        : cfg_stg;
    commit_word  = {phase_cmt, freq_cmt, amp_cmt, env_word_cmt, cfg_cmt};
  end

  // Handshake decode; a pop frees the slot the same-cycle push will use
  always_comb begin
    pop  = out_valid & out_ready;
    push = cstrobe_in & (~full | pop);
    drop = cstrobe_in & full & ~pop;
    unique case ({push, pop})
      2'b10:   level_next = level + ONE_CNT;
      2'b01:   level_next = level - ONE_CNT;
      default: level_next = level;
    endcase
  end

  assign head_word = mem[rd_ptr];

  // Field staging: each field loads independently on its own write strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_stg    <= '0;
      freq_stg     <= '0;
      amp_stg      <= '0;
      env_word_stg <= '0;
      cfg_stg      <= '0;
    end else begin
      if (phase_write_en)    phase_stg    <= phase_offs_in;
      if (freq_write_en)     freq_stg     <= freq_in;
      if (amp_write_en)      amp_stg      <= amp_in;
      if (env_word_write_en) env_word_stg <= env_word_in;
      if (cfg_write_en)      cfg_stg      <= cfg_in;
    end
  end

  // FIFO storage write; contents are don't-care until referenced by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= commit_word;
  end

  // Pointers and occupancy; level/full/out_valid all follow level_next so they
  // stay mutually consistent every cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      level     <= level_next;
      full      <= (level_next == DEPTH_CNT);
      out_valid <= (level_next != '0);
    end
  end

  // Sticky overflow; a dropped commit outranks a same-cycle clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Issued pulse: head entry is registered on pop, held otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase    <= '0;
      freq     <= '0;
      amp      <= '0;
      env_word <= '0;
      cfg      <= '0;
      cstrobe  <= 1'b0;
    end else begin
      cstrobe <= pop;
      if (pop) begin
        {phase, freq, amp, env_word, cfg} <= head_word;
      end
    end
  end

endmodule

// File: tb/tb_pulse_reg_queue.sv
// Testbench for pulse_reg_queue: a table of hand-computed vectors for the
// basic issue path, then hand-written sequences for overflow, full-with-pop
// streaming, async reset mid-drain and handshake toggling, checked against a
// small queue-based reference.
module tb_pulse_reg_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic [16:0] phase_offs_in;
  logic [8:0]  freq_in;
  logic [15:0] amp_in;
  logic [23:0] env_word_in;
  logic [3:0]  cfg_in;
  logic        phase_write_en, freq_write_en, amp_write_en;
  logic        env_word_write_en, cfg_write_en;
  logic        cstrobe_in, out_ready, overflow_clr;
  logic [16:0] phase;
  logic [8:0]  freq;
  logic [15:0] amp;
  logic [23:0] env_word;
  logic [3:0]  cfg;
  logic        cstrobe, out_valid, full, overflow;
  logic [3:0]  level;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;

  always #5 clk = ~clk;

  pulse_reg_queue #(
    .PHASE_WIDTH(17), .FREQ_WIDTH(9), .AMP_WIDTH(16), .CFG_WIDTH(4),
    .ENV_WORD_WIDTH(24), .DEPTH(8), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .phase_offs_in(phase_offs_in), .freq_in(freq_in), .amp_in(amp_in),
    .env_word_in(env_word_in), .cfg_in(cfg_in),
    .phase_write_en(phase_write_en), .freq_write_en(freq_write_en),
    .amp_write_en(amp_write_en), .env_word_write_en(env_word_write_en),
    .cfg_write_en(cfg_write_en),
    .cstrobe_in(cstrobe_in), .out_ready(out_ready), .overflow_clr(overflow_clr),
    .phase(phase), .freq(freq), .amp(amp), .env_word(env_word), .cfg(cfg),
    .cstrobe(cstrobe), .out_valid(out_valid), .level(level), .full(full),
    .overflow(overflow)
  );

  typedef struct {
    logic [4:0]  we;   // {phase, freq, amp, env, cfg}
    logic [16:0] ph;
    logic [8:0]  fr;
    logic [15:0] am;
    logic [23:0] en;
    logic [3:0]  cf;
    logic        cs, rdy, oclr;
    logic        e_cs, e_val;
    logic [3:0]  e_lvl;
    logic        e_full, e_ovf;
    logic [69:0] e_pulse;
  } vec_t;

  vec_t tbl [7];

  // Reference state for the hand-written sequences
  logic [69:0] ref_q [$];
  logic [69:0] ref_last;
  logic [69:0] ref_stg;
  logic        ref_ovf;
  logic        ref_cs;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] w, input logic [16:0] ph, input logic [8:0] fr,
                       input logic [15:0] am, input logic [23:0] en, input logic [3:0] cf,
                       input logic cs, input logic rdy, input logic oclr);
    {phase_write_en, freq_write_en, amp_write_en, env_word_write_en, cfg_write_en} = w;
    phase_offs_in = ph; freq_in = fr; amp_in = am; env_word_in = en; cfg_in = cf;
    cstrobe_in = cs; out_ready = rdy; overflow_clr = oclr;
  endtask

  function automatic logic [69:0] pulse_out();
    return {phase, freq, amp, env_word, cfg};
  endfunction

  task automatic ref_reset();
    ref_q.delete();
    ref_last = '0;
    ref_stg  = '0;
    ref_ovf  = 1'b0;
    ref_cs   = 1'b0;
  endtask

  // One clock cycle against the reference queue
  task automatic cyc(input logic [4:0] w, input logic [16:0] ph, input logic [8:0] fr,
                     input logic [15:0] am, input logic [23:0] en, input logic [3:0] cf,
                     input logic cs, input logic rdy, input logic oclr);
    logic [69:0] cw;
    logic [69:0] nw;
    logic        do_pop, do_push;
    nw = {ph, fr, am, en, cf};
    cw = ref_stg;
    if (w[4]) cw[69:53] = nw[69:53];
    if (w[3]) cw[52:44] = nw[52:44];
    if (w[2]) cw[43:28] = nw[43:28];
    if (w[1]) cw[27:4]  = nw[27:4];
    if (w[0]) cw[3:0]   = nw[3:0];
    do_pop  = (ref_q.size() > 0) && rdy;
    do_push = cs && ((ref_q.size() < 8) || do_pop);
    if (cs && !do_push) ref_ovf = 1'b1;
    else if (oclr)      ref_ovf = 1'b0;
    ref_cs = do_pop;
    if (do_pop) ref_last = ref_q.pop_front();
    if (do_push) ref_q.push_back(cw);
    ref_stg = cw;
    drive(w, ph, fr, am, en, cf, cs, rdy, oclr);
    @(posedge clk);
    #1;
    if (cstrobe) n_strobe++;
    chk("cstrobe", 70'(cstrobe), 70'(ref_cs));
    chk("out_valid", 70'(out_valid), 70'(ref_q.size() > 0));
    chk("level", 70'(level), 70'(ref_q.size()));
    chk("full", 70'(full), 70'(ref_q.size() == 8));
    chk("overflow", 70'(overflow), 70'(ref_ovf));
    chk("pulse", pulse_out(), ref_last);
  endtask

  task automatic idle(input logic rdy);
    cyc(5'b0, '0, '0, '0, '0, '0, 1'b0, rdy, 1'b0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int commits;
    int s0;
    tbl[0] = '{5'h1F, 17'h1ABCD, 9'h55, 16'h7FFF, 24'h123040, 4'h9, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 70'h0};
    tbl[1] = '{5'h00, 17'h00FFF, 9'h1FF, 16'hDEAD, 24'hFFFFFF, 4'hF, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 70'h0};
    tbl[2] = '{5'h00, 17'h0, 9'h0, 16'h0, 24'h0, 4'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 1'b0, 4'd0, 1'b0, 1'b0, {17'h1ABCD, 9'h55, 16'h7FFF, 24'h123040, 4'h9}};
    tbl[3] = '{5'h00, 17'h0, 9'h0, 16'h0, 24'h0, 4'h0, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 4'd0, 1'b0, 1'b0, {17'h1ABCD, 9'h55, 16'h7FFF, 24'h123040, 4'h9}};
    tbl[4] = '{5'h04, 17'h00001, 9'h002, 16'h0100, 24'h000003, 4'h4, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b1, 4'd1, 1'b0, 1'b0, {17'h1ABCD, 9'h55, 16'h7FFF, 24'h123040, 4'h9}};
    tbl[5] = '{5'h00, 17'h0, 9'h0, 16'h0, 24'h0, 4'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 1'b0, 4'd0, 1'b0, 1'b0, {17'h1ABCD, 9'h55, 16'h0100, 24'h123040, 4'h9}};
    tbl[6] = '{5'h00, 17'h0, 9'h0, 16'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 4'd0, 1'b0, 1'b0, {17'h1ABCD, 9'h55, 16'h0100, 24'h123040, 4'h9}};

    rstn = 1'b0;
    drive(5'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 70'(level), 70'd0);
    chk("rst_valid", 70'(out_valid), 70'd0);
    chk("rst_full", 70'(full), 70'd0);
    chk("rst_ovf", 70'(overflow), 70'd0);
    chk("rst_cstrobe", 70'(cstrobe), 70'd0);
    chk("rst_pulse", pulse_out(), 70'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic issue path and same-cycle field write into a commit
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].we, tbl[i].ph, tbl[i].fr, tbl[i].am, tbl[i].en, tbl[i].cf,
            tbl[i].cs, tbl[i].rdy, tbl[i].oclr);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_cstrobe", i), 70'(cstrobe), 70'(tbl[i].e_cs));
      chk($sformatf("tbl%0d_valid", i), 70'(out_valid), 70'(tbl[i].e_val));
      chk($sformatf("tbl%0d_level", i), 70'(level), 70'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_full", i), 70'(full), 70'(tbl[i].e_full));
      chk($sformatf("tbl%0d_ovf", i), 70'(overflow), 70'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_pulse", i), pulse_out(), tbl[i].e_pulse);
    end

    // Restart from reset so the reference starts from a known state
    @(negedge clk);
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    ref_reset();

    // Overflow: 9 commits into 8 entries, 10th commit with a clear (set wins)
    for (int i = 0; i < 9; i++)
      cyc(5'b10001, 17'(100 + i), '0, '0, '0, 4'(i), 1'b1, 1'b0, 1'b0);
    chk("ovf_level", 70'(level), 70'd8);
    chk("ovf_full", 70'(full), 70'd1);
    chk("ovf_flag", 70'(overflow), 70'd1);
    cyc(5'b10000, 17'd999, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("ovf_set_wins", 70'(overflow), 70'd1);
    s0 = n_strobe;
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      chk($sformatf("drain%0d_phase", i), 70'(phase), 70'(100 + i));
    end
    chk("drain_strobes", 70'(n_strobe - s0), 70'd8);
    idle(1'b1);
    cyc(5'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("ovf_cleared", 70'(overflow), 70'd0);

    // Full with pop every cycle: push accepted, pointers wrap, order kept
    for (int i = 0; i < 8; i++)
      cyc(5'b10000, 17'(200 + i), '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(5'b11000, 17'(300 + i), 9'(i), '0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("stream_level", 70'(level), 70'd8);
    chk("stream_ovf", 70'(overflow), 70'd0);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Async reset mid-drain with 5 entries queued
    for (int i = 0; i < 5; i++)
      cyc(5'b00100, '0, '0, 16'(16'h4000 + i), '0, '0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_level", 70'(level), 70'd0);
    chk("arst_valid", 70'(out_valid), 70'd0);
    chk("arst_full", 70'(full), 70'd0);
    chk("arst_cstrobe", 70'(cstrobe), 70'd0);
    chk("arst_pulse", pulse_out(), 70'd0);
    #2;
    rstn = 1'b1;
    ref_reset();
    s0 = n_strobe;
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("arst_no_strobe", 70'(n_strobe - s0), 70'd0);
    cyc(5'b00001, '0, '0, '0, '0, 4'hA, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("arst_recommit_cfg", 70'(cfg), 70'hA);

    // Toggling ready with a commit every third cycle
    s0 = n_strobe;
    commits = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) commits++;
      cyc(5'b01000, '0, 9'(16 + i), '0, '0, '0, (i % 3 == 0), (i % 2 == 1), 1'b0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("toggle_strobes", 70'(n_strobe - s0), 70'(commits));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
